// File: rtl/pixel_pkg.sv
// Shared types for the per-pixel filter pipeline: channel width, raster
// coordinate width and the packed RGB pixel.
package pixel_pkg;

  localparam int PIX_W = 8;
  localparam int POS_W = 12;
  localparam int RGB_W = 3 * PIX_W;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/pixel_feeder_if.sv
// Upstream pixel stream plus filter-side presentation bus of pixel_feeder.
// SYNC_ERR exists only when PIXEL_FEEDER_SOF_RESYNC_EN is defined.
interface pixel_feeder_if;
  import pixel_pkg::*;

  logic             S_VALID;
  logic             S_READY;
  logic [RGB_W-1:0] S_DATA;
  logic             S_SOF;
  logic             SINK_SPACE;
  logic             READY;
  logic             RDEN;
  pos_t             POSX;
  pos_t             POSY;
  logic [PIX_W-1:0] OUT_R;
  logic [PIX_W-1:0] OUT_G;
  logic [PIX_W-1:0] OUT_B;
  logic             FRAME_DONE;
`ifdef PIXEL_FEEDER_SOF_RESYNC_EN
  logic             SYNC_ERR;

  modport master (
    output S_VALID, S_DATA, S_SOF, SINK_SPACE, RDEN,
    input  S_READY, READY, POSX, POSY, OUT_R, OUT_G, OUT_B, FRAME_DONE, SYNC_ERR
  );

  modport slave (
    input  S_VALID, S_DATA, S_SOF, SINK_SPACE, RDEN,
    output S_READY, READY, POSX, POSY, OUT_R, OUT_G, OUT_B, FRAME_DONE, SYNC_ERR
  );
`else
  modport master (
    output S_VALID, S_DATA, S_SOF, SINK_SPACE, RDEN,
    input  S_READY, READY, POSX, POSY, OUT_R, OUT_G, OUT_B, FRAME_DONE
  );

  modport slave (
    input  S_VALID, S_DATA, S_SOF, SINK_SPACE, RDEN,
    output S_READY, READY, POSX, POSY, OUT_R, OUT_G, OUT_B, FRAME_DONE
  );
`endif

endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with a registered head word and
// registered full/empty flags. DEPTH must be a power of two, >= 2.
module sync_fifo_fwft #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;

  // Flags come from registers only, so a pop never frees a slot for a
  // push in the same cycle.
  assign push       = wr_en && !full;
  assign pop        = rd_en && !empty;
  assign rd_ptr_nxt = rd_ptr + AW'(1);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      dout   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
      // Head reload: next stored word, or the incoming word when the
      // queue is (or is about to be) otherwise empty. When drained the
      // head keeps the last popped word.
      if (pop && count > CW'(1))
        dout <= mem[rd_ptr_nxt];
      else if (push && (empty || (pop && count == CW'(1))))
        dout <= din;
    end
  end

endmodule

// File: rtl/pixel_feeder.sv
// Buffers the upstream RGB stream and presents one pixel per cycle with its
// raster position. Optional SOF resync: PIXEL_FEEDER_SOF_RESYNC_EN.
module pixel_feeder
  import pixel_pkg::*;
#(
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic         CLK,
  input  logic         RST,
  pixel_feeder_if.slave bus
);

`ifdef PIXEL_FEEDER_SOF_RESYNC_EN
  localparam int FW = RGB_W + 1;
`else
  localparam int FW = RGB_W;
`endif

  localparam pos_t X_LAST = pos_t'(FRAME_W - 1);
  localparam pos_t Y_LAST = pos_t'(FRAME_H - 1);

  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          alive;
  logic          resync;
  logic          ready;
  logic          pop;
  rgb_t          head;
  pos_t          posx;
  pos_t          posy;
  logic          frame_done;

`ifdef PIXEL_FEEDER_SOF_RESYNC_EN
  logic          sync_err;

  assign fifo_din = {bus.S_SOF, bus.S_DATA};
  // A SOF pixel arriving mid-frame costs one dead cycle while the
  // counters snap back to the origin.
  assign resync   = !fifo_empty && fifo_dout[RGB_W] && ((posx != '0) || (posy != '0));
  assign bus.SYNC_ERR = sync_err;
`else
  assign fifo_din = bus.S_DATA;
  assign resync   = 1'b0;
`endif

  sync_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .wr_en (bus.S_VALID && alive),
    .din   (fifo_din),
    .rd_en (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head  = rgb_t'(fifo_dout[RGB_W-1:0]);
  // Filters cannot stall, so only present when the sink can take a result.
  assign ready = !fifo_empty && bus.SINK_SPACE && !resync;
  assign pop   = bus.RDEN && ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alive      <= 1'b0;
      posx       <= '0;
      posy       <= '0;
      frame_done <= 1'b0;
`ifdef PIXEL_FEEDER_SOF_RESYNC_EN
      sync_err   <= 1'b0;
`endif
    end else begin
      alive      <= 1'b1;
      frame_done <= 1'b0;
`ifdef PIXEL_FEEDER_SOF_RESYNC_EN
      sync_err   <= resync;
`endif
      if (resync) begin
        posx <= '0;
        posy <= '0;
      end else if (pop) begin
        if (posx == X_LAST) begin
          posx <= '0;
          if (posy == Y_LAST) begin
            posy       <= '0;
            frame_done <= 1'b1;
          end else begin
            posy <= posy + pos_t'(1);
          end
        end else begin
          posx <= posx + pos_t'(1);
        end
      end
    end
  end

  assign bus.S_READY    = alive && !fifo_full;
  assign bus.READY      = ready;
  assign bus.POSX       = posx;
  assign bus.POSY       = posy;
  assign bus.OUT_R      = head.r;
  assign bus.OUT_G      = head.g;
  assign bus.OUT_B      = head.b;
  assign bus.FRAME_DONE = frame_done;

endmodule

// File: doc/pixel_feeder.md
Name: pixel_feeder

Overview:
- Upstream stage of the per-pixel filter pipeline (grayscale and siblings).
- Buffers an incoming RGB pixel stream in a small first-word-fall-through FIFO and presents one pixel per cycle on the filter-side interface (READY/RDEN, IN_R/G/B).
- Generates the POSX/POSY raster coordinates for that pixel.
- Filters have no backpressure, so the feeder gates READY with downstream sink space.

Parameters:
- FRAME_W, 640, pixels per line (1..4095)
- FRAME_H, 480, lines per frame (1..4095)
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- S_VALID  in  1  upstream pixel valid
- S_READY  out  1  feeder can accept a pixel
- S_DATA  in  24  pixel {R[23:16], G[15:8], B[7:0]}
- S_SOF  in  1  start-of-frame flag, qualified by S_VALID
- SINK_SPACE  in  1  downstream writer can absorb a result in 1 cycle
- READY  out  1  pixel presented to filter this cycle
- RDEN  in  1  filter consumes the presented pixel
- POSX  out  12  column of the presented pixel
- POSY  out  12  row of the presented pixel
- OUT_R  out  8  presented red
- OUT_G  out  8  presented green
- OUT_B  out  8  presented blue
- FRAME_DONE  out  1  one-cycle pulse after the last pixel of a frame is consumed

Behaviour:
- Reset (asynchronous, RST=1):
  - FIFO empty; S_READY=0 while RST is high, 1 on the first cycle after release.
  - READY=0, POSX=0, POSY=0, OUT_*=0, FRAME_DONE=0.
- Push: S_VALID && S_READY stores S_DATA (and S_SOF when the option is enabled).
- S_READY = !full, derived from the registered occupancy only. A push is never accepted when full, even if a pop occurs in the same cycle.
- Head: OUT_* are registered and hold the head entry (FWFT).
- READY = !empty && SINK_SPACE, combinational from registered occupancy and SINK_SPACE.
- Pop: occurs only when RDEN && READY. RDEN while READY=0 is ignored; no state change.
- Empty pipe: a pixel pushed in cycle N is presented (READY=1 if SINK_SPACE) at the earliest in cycle N+1. No same-cycle bypass.
- Simultaneous push and pop with 0 < count < FIFO_DEPTH: count unchanged; head advances.
- Sustained throughput is one pixel per cycle with no bubbles while S_VALID and SINK_SPACE stay high.
- When empty, OUT_* hold the last popped value. OUT_* are only meaningful while READY=1.
- Coordinates: POSX/POSY always describe the head pixel and advance on each pop.
  - POSX increments; at FRAME_W-1 it wraps to 0 and POSY increments.
  - Popping pixel (FRAME_W-1, FRAME_H-1) sets POSX=0, POSY=0, and FRAME_DONE=1 in the next cycle, for exactly one cycle.
- Counter arithmetic is 12-bit unsigned; no overflow is possible within the parameter ranges.
- Reset mid-frame: FIFO contents discarded, counters return to (0,0), any pending FRAME_DONE is cancelled.

Optional Feature:
- Macro: PIXEL_FEEDER_SOF_RESYNC_EN
- Enabled:
  - The S_SOF bit is stored per FIFO entry.
  - When an entry carrying SOF=1 reaches the head while (POSX,POSY) != (0,0), the counters are forced to (0,0) for that pixel before it is presented (READY held low for that one cycle).
  - A one-cycle SYNC_ERR output pulse is asserted (extra port, width 1, reset 0).
- Disabled: S_SOF is ignored and not stored, SYNC_ERR does not exist, and coordinates are purely count-based.

Decomposition:
- Shared package pixel_pkg: PIX_W=8, POS_W=12, packed rgb_t {r,g,b}. All filter stages use it.
- Sub-module sync_fifo_fwft:
  - parameterised width/depth; registered head, full, empty, count.
  - Instantiated once; reused later by the downstream writer.
- Counters and the READY gating stay in pixel_feeder.

Test Plan:
- Reset then push 3 pixels (0x102030, 0x405060, 0x708090) with SINK_SPACE=1 and RDEN tied to READY -> READY rises 1 cycle after the first push; OUT_R=0x10,0x40,0x70 on consecutive cycles; POSX=0,1,2; POSY=0.
- FRAME_W=4, FRAME_H=2, stream 8 pixels -> POSX sequence 0,1,2,3,0,1,2,3; POSY=0 then 1; FRAME_DONE pulses once, 1 cycle after the 8th pop; counters return to (0,0).
- FIFO_DEPTH=4, SINK_SPACE=0, push 6 pixels -> S_READY drops after 4 accepts; READY stays 0. Raise SINK_SPACE -> 4 pops, then the remaining 2 are accepted and presented in order.
- Hold RDEN=1 with FIFO empty for 5 cycles -> no coordinate change, READY=0, OUT_* unchanged.
- Assert RST mid-frame at POSX=2, POSY=1 with 3 entries queued -> READY=0 and POSX=POSY=0 immediately; the next pushed pixel is presented at (0,0).
- With PIXEL_FEEDER_SOF_RESYNC_EN: FRAME_W=4, send 2 pixels then one with S_SOF=1 -> third pixel presented at (0,0); SYNC_ERR pulses once for 1 cycle.
